// File: rtl/sda_gmem_axi_slave_mem_if.sv
// AXI4 full-protocol bundle between the kernel gmem master and the memory slave.
// The lock/cache/prot/qos/region fields are carried through but are ignored by the slave.
interface sda_gmem_axi_slave_mem_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int USER_WIDTH = 1
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [ID_WIDTH-1:0]     awid;
  logic [USER_WIDTH-1:0]   awuser;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [3:0]              awregion;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic [USER_WIDTH-1:0]   wuser;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic [ID_WIDTH-1:0]     bid;
  logic [USER_WIDTH-1:0]   buser;
  logic                    bvalid;
  logic                    bready;

  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [ID_WIDTH-1:0]     arid;
  logic [USER_WIDTH-1:0]   aruser;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [3:0]              arregion;
  logic                    arvalid;
  logic                    arready;

  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [ID_WIDTH-1:0]     rid;
  logic [USER_WIDTH-1:0]   ruser;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awid, awuser, awlock, awcache, awprot, awqos, awregion, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bresp, bid, buser, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arid, aruser, arlock, arcache, arprot, arqos, arregion, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rid, ruser, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awid, awuser, awlock, awcache, awprot, awqos, awregion, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bresp, bid, buser, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arid, aruser, arlock, arcache, arprot, arqos, arregion, arvalid,
    output arready,
    output rdata, rresp, rlast, rid, ruser, rvalid,
    input  rready
  );
endinterface

// File: rtl/sda_gmem_axi_slave_mem.sv
// AXI4 slave over a word RAM: one burst per direction, read beat every 2 cycles (first at AR+2), B/R held until ready.
// Define GMEM_SLAVE_BACKPRESSURE_EN to throttle wready and read-data entry with a 16-bit LFSR.
module sda_gmem_axi_slave_mem #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 1,
  parameter int USER_WIDTH     = 1,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input logic                      clk,
  input logic                      reset,
  sda_gmem_axi_slave_mem_if.slave  s_axi
);
  localparam int IDX_LO = $clog2(DATA_WIDTH/8);
  localparam int IDX_HI = MEM_ADDR_WIDTH + IDX_LO - 1;
  localparam int NBYTES = DATA_WIDTH/8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  logic [DATA_WIDTH-1:0] mem [2**MEM_ADDR_WIDTH];

  w_state_e                w_state_q, w_state_d;
  logic [MEM_ADDR_WIDTH-1:0] w_idx_q, w_idx_d;
  logic [7:0]              w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [1:0]              w_burst_q, w_burst_d;
  logic [ID_WIDTH-1:0]     w_id_q, w_id_d;
  logic [USER_WIDTH-1:0]   w_user_q, w_user_d;
  logic                    w_oor_q, w_oor_d, w_err_q, w_err_d;

  r_state_e                r_state_q, r_state_d;
  logic [MEM_ADDR_WIDTH-1:0] r_idx_q, r_idx_d;
  logic [7:0]              r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [1:0]              r_burst_q, r_burst_d;
  logic [ID_WIDTH-1:0]     r_id_q, r_id_d;
  logic [USER_WIDTH-1:0]   r_user_q, r_user_d;
  logic                    r_oor_q, r_oor_d, r_err_q, r_err_d;
  logic [DATA_WIDTH-1:0]   rdata_q;

  // Cleared by reset so every ready/valid is low for the cycle following a reset edge.
  logic out_en_q;
  logic awready, wready, bvalid, arready, rvalid, rlast, w_we;
  logic bp_w_ok, bp_r_ok;

`ifdef GMEM_SLAVE_BACKPRESSURE_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end
  assign bp_w_ok = lfsr_q[0];
  assign bp_r_ok = lfsr_q[1];
`else
  assign bp_w_ok = 1'b1;
  assign bp_r_ok = 1'b1;
`endif

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_burst_d = w_burst_q;
    w_id_d    = w_id_q;
    w_user_d  = w_user_q;
    w_oor_d   = w_oor_q;
    w_err_d   = w_err_q;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    w_we      = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready = out_en_q;
        if (s_axi.awvalid && out_en_q) begin
          w_idx_d   = s_axi.awaddr[IDX_HI:IDX_LO];
          w_len_d   = s_axi.awlen;
          w_burst_d = s_axi.awburst;
          w_id_d    = s_axi.awid;
          w_user_d  = s_axi.awuser;
          w_cnt_d   = 8'd0;
          w_oor_d   = |s_axi.awaddr[ADDR_WIDTH-1:IDX_HI+1];
          w_err_d   = w_oor_d | s_axi.awburst[1];
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        wready = out_en_q & bp_w_ok;
        if (s_axi.wvalid && wready) begin
          w_we    = ~w_oor_q;
          // Beat count terminates the burst; wlast is only cross-checked.
          if (s_axi.wlast != (w_cnt_q == w_len_q)) w_err_d = 1'b1;
          w_cnt_d = w_cnt_q + 8'd1;
          if (w_burst_q != 2'b00) w_idx_d = w_idx_q + 1'b1;
          if (w_cnt_q == w_len_q) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = out_en_q;
        if (s_axi.bready && out_en_q) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_burst_d = r_burst_q;
    r_id_d    = r_id_q;
    r_user_d  = r_user_q;
    r_oor_d   = r_oor_q;
    r_err_d   = r_err_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready = out_en_q;
        if (s_axi.arvalid && out_en_q) begin
          r_idx_d   = s_axi.araddr[IDX_HI:IDX_LO];
          r_len_d   = s_axi.arlen;
          r_burst_d = s_axi.arburst;
          r_id_d    = s_axi.arid;
          r_user_d  = s_axi.aruser;
          r_cnt_d   = 8'd0;
          r_oor_d   = |s_axi.araddr[ADDR_WIDTH-1:IDX_HI+1];
          r_err_d   = r_oor_d | s_axi.arburst[1];
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        if (bp_r_ok) r_state_d = R_DATA;
      end
      R_DATA: begin
        rvalid = out_en_q;
        rlast  = (r_cnt_q == r_len_q);
        if (s_axi.rready && out_en_q) begin
          if (rlast) begin
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d = r_cnt_q + 8'd1;
            if (r_burst_q != 2'b00) r_idx_d = r_idx_q + 1'b1;
            r_state_d = R_FETCH;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_en_q  <= 1'b0;
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_burst_q <= '0;
      w_id_q    <= '0;
      w_user_q  <= '0;
      w_oor_q   <= 1'b0;
      w_err_q   <= 1'b0;
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_burst_q <= '0;
      r_id_q    <= '0;
      r_user_q  <= '0;
      r_oor_q   <= 1'b0;
      r_err_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      out_en_q  <= 1'b1;
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_burst_q <= w_burst_d;
      w_id_q    <= w_id_d;
      w_user_q  <= w_user_d;
      w_oor_q   <= w_oor_d;
      w_err_q   <= w_err_d;
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_burst_q <= r_burst_d;
      r_id_q    <= r_id_d;
      r_user_q  <= r_user_d;
      r_oor_q   <= r_oor_d;
      r_err_q   <= r_err_d;
      // Read-first: a same-edge write to this word lands after the sample.
      if (r_state_q == R_FETCH) rdata_q <= r_oor_q ? '0 : mem[r_idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (w_we && !reset) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (s_axi.wstrb[i]) mem[w_idx_q][i*8 +: 8] <= s_axi.wdata[i*8 +: 8];
      end
    end
  end

  assign s_axi.awready = awready;
  assign s_axi.wready  = wready;
  assign s_axi.bvalid  = bvalid;
  assign s_axi.bresp   = {w_err_q, 1'b0};
  assign s_axi.bid     = w_id_q;
  assign s_axi.buser   = w_user_q;
  assign s_axi.arready = arready;
  assign s_axi.rvalid  = rvalid;
  assign s_axi.rlast   = rlast;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = {r_err_q, 1'b0};
  assign s_axi.rid     = r_id_q;
  assign s_axi.ruser   = r_user_q;

  logic unused_sigs;
  assign unused_sigs = ^{s_axi.awsize, s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos,
                         s_axi.awregion, s_axi.arsize, s_axi.arlock, s_axi.arcache, s_axi.arprot,
                         s_axi.arqos, s_axi.arregion, s_axi.wuser,
                         s_axi.awaddr[IDX_LO-1:0], s_axi.araddr[IDX_LO-1:0]};
endmodule

// File: tb/tb_sda_gmem_axi_slave_mem.sv
// Directed bench for sda_gmem_axi_slave_mem: shadow-memory model feeds B/R expectation queues.
module tb_sda_gmem_axi_slave_mem;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sda_gmem_axi_slave_mem_if ax ();
  sda_gmem_axi_slave_mem dut (.clk(clk), .reset(reset), .s_axi(ax));

  typedef struct packed {logic [1:0] resp; logic id;} bexp_t;
  typedef struct packed {logic [31:0] data; logic [1:0] resp; logic last; logic id;} rexp_t;

  bexp_t bq[$];
  rexp_t rq[$];
  logic [31:0] model [1024];
  logic [31:0] wd [8];
  logic [3:0]  ws [8];
  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_burst(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic id, input int early, input int hold);
    int idx = int'(addr[11:2]);
    bit oor = |addr[63:12];
    bit err = oor | burst[1];
    bexp_t e;
    int n;
    ax.awaddr = addr; ax.awlen = len; ax.awburst = burst; ax.awid = id; ax.awvalid = 1'b1;
    n = 0;
    while (!ax.awready && n < 50) begin @(negedge clk); n++; end
    if (!ax.awready) chk("aw_timeout", ax.awready, 1);
    @(negedge clk);
    ax.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      ax.wdata = wd[i]; ax.wstrb = ws[i];
      ax.wlast = (early >= 0) ? (i == early) : (i == int'(len));
      ax.wvalid = 1'b1;
      if (ax.wlast != (i == int'(len))) err = 1'b1;
      n = 0;
      while (!ax.wready && n < 50) begin @(negedge clk); n++; end
      if (!ax.wready) chk("w_timeout", ax.wready, 1);
      if (!oor)
        for (int b = 0; b < 4; b++) if (ws[i][b]) model[idx][b*8 +: 8] = wd[i][b*8 +: 8];
      if (burst != 2'b00) idx = (idx + 1) % 1024;
      @(negedge clk);
    end
    ax.wvalid = 1'b0; ax.wlast = 1'b0;
    bq.push_back('{resp: err ? 2'b10 : 2'b00, id: id});
    n = 0;
    while (!ax.bvalid && n < 50) begin @(negedge clk); n++; end
    e = bq.pop_front();
    chk("bresp", ax.bresp, e.resp);
    chk("bid", ax.bid, e.id);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("b_hold", {ax.bvalid, ax.bresp, ax.bid}, {1'b1, e.resp, e.id});
    end
    ax.bready = 1'b1;
    @(negedge clk);
    ax.bready = 1'b0;
  endtask

  task automatic rd_burst(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic id, input int hold, input bit lat_chk);
    int idx = int'(addr[11:2]);
    bit oor = |addr[63:12];
    rexp_t e;
    int n;
    for (int i = 0; i <= int'(len); i++) begin
      rq.push_back('{data: oor ? 32'h0 : model[idx], resp: (oor | burst[1]) ? 2'b10 : 2'b00,
                     last: (i == int'(len)), id: id});
      if (burst != 2'b00) idx = (idx + 1) % 1024;
    end
    ax.araddr = addr; ax.arlen = len; ax.arburst = burst; ax.arid = id; ax.arvalid = 1'b1;
    n = 0;
    while (!ax.arready && n < 50) begin @(negedge clk); n++; end
    if (!ax.arready) chk("ar_timeout", ax.arready, 1);
    @(negedge clk);
    ax.arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!ax.rvalid && n < 50) begin @(negedge clk); n++; end
`ifndef GMEM_SLAVE_BACKPRESSURE_EN
      if (i == 0 && lat_chk) chk("r_latency", n, 1);
`endif
      e = rq.pop_front();
      chk("rdata", ax.rdata, e.data);
      chk("rresp", ax.rresp, e.resp);
      chk("rlast", ax.rlast, e.last);
      chk("rid", ax.rid, e.id);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk("r_hold", {ax.rvalid, ax.rdata, ax.rresp, ax.rid}, {1'b1, e.data, e.resp, e.id});
      end
      ax.rready = 1'b1;
      @(negedge clk);
      ax.rready = 1'b0;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {ax.awready, ax.wready, ax.bvalid, ax.arready, ax.rvalid, ax.rlast}, 6'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ax.awaddr = '0; ax.awlen = '0; ax.awsize = 3'd2; ax.awburst = 2'b01; ax.awid = '0; ax.awuser = '0;
    ax.awlock = '0; ax.awcache = '0; ax.awprot = '0; ax.awqos = '0; ax.awregion = '0; ax.awvalid = 1'b0;
    ax.wdata = '0; ax.wstrb = '0; ax.wlast = 1'b0; ax.wuser = '0; ax.wvalid = 1'b0; ax.bready = 1'b0;
    ax.araddr = '0; ax.arlen = '0; ax.arsize = 3'd2; ax.arburst = 2'b01; ax.arid = '0; ax.aruser = '0;
    ax.arlock = '0; ax.arcache = '0; ax.arprot = '0; ax.arqos = '0; ax.arregion = '0; ax.arvalid = 1'b0;
    ax.rready = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset_handshake");
    chk("reset_resp", {ax.bresp, ax.rresp, ax.bid, ax.rid}, 6'b0);
    chk("reset_rdata", ax.rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Single beat write then read
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    wr_burst(64'h40, 8'd0, 2'b01, 1'b0, -1, 0);
    rd_burst(64'h40, 8'd0, 2'b01, 1'b0, 0, 1'b1);

    // INCR burst over a prefilled region, partial strobe on beat 2
    for (int i = 0; i < 8; i++) begin wd[i] = 32'hF00D_0000 + i; ws[i] = 4'hF; end
    wr_burst(64'h100, 8'd7, 2'b01, 1'b0, -1, 0);
    for (int i = 0; i < 8; i++) begin wd[i] = i; ws[i] = (i == 2) ? 4'h3 : 4'hF; end
    wr_burst(64'h100, 8'd7, 2'b01, 1'b1, -1, 0);
    rd_burst(64'h100, 8'd7, 2'b01, 1'b1, 0, 1'b0);
    chk("incr_beat2_model", model[66], 32'hF00D_0002);

    // Index wrap at the top of the RAM, then FIXED burst
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    for (int i = 0; i < 4; i++) ws[i] = 4'hF;
    wr_burst(64'hFF8, 8'd3, 2'b01, 1'b0, -1, 0);
    rd_burst(64'hFF8, 8'd3, 2'b01, 1'b0, 0, 1'b0);
    rd_burst(64'h0, 8'd1, 2'b01, 1'b1, 0, 1'b0);
    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
    wr_burst(64'h20, 8'd3, 2'b00, 1'b0, -1, 0);
    rd_burst(64'h20, 8'd0, 2'b01, 1'b0, 0, 1'b0);

    // Error responses
    wd[0] = 32'h12345678;
    wr_burst(64'h1_0000_0000, 8'd0, 2'b01, 1'b1, -1, 0);
    rd_burst(64'h1_0000_0000, 8'd0, 2'b01, 1'b1, 0, 1'b0);
    rd_burst(64'h0, 8'd0, 2'b01, 1'b0, 0, 1'b0);
    wd[0] = 32'h77; wd[1] = 32'h88;
    wr_burst(64'h400, 8'd1, 2'b10, 1'b0, -1, 0);
    for (int i = 0; i < 4; i++) wd[i] = 32'h500 + i;
    wr_burst(64'h500, 8'd3, 2'b01, 1'b0, 1, 0);
    rd_burst(64'h500, 8'd3, 2'b01, 1'b0, 0, 1'b0);

    // Concurrent write and read with responses held off
    wd[0] = 32'h6006_6006;
    fork
      wr_burst(64'h600, 8'd0, 2'b01, 1'b0, -1, 5);
      rd_burst(64'h100, 8'd0, 2'b01, 1'b1, 5, 1'b0);
    join

    // Reset in the middle of a write burst
    ax.awaddr = 64'h300; ax.awlen = 8'd7; ax.awburst = 2'b01; ax.awid = 1'b0; ax.awvalid = 1'b1;
    @(negedge clk);
    ax.awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ax.wdata = 32'hBAD0_0000 + i; ax.wstrb = 4'hF; ax.wlast = 1'b0; ax.wvalid = 1'b1;
      @(negedge clk);
    end
    ax.wvalid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk_quiet("midburst_reset");
    reset = 1'b0;
    @(negedge clk);
    wd[0] = 32'h5A5A_5A5A; ws[0] = 4'hF;
    wr_burst(64'h0, 8'd0, 2'b01, 1'b1, -1, 0);
    rd_burst(64'h0, 8'd0, 2'b01, 1'b1, 0, 1'b1);

    chk("scoreboard_empty", bq.size() + rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/sda_gmem_axi_slave_mem.md
Name: sda_gmem_axi_slave_mem

Overview:
- AXI4 full-protocol slave responder backed by on-chip word RAM; the far end of the kernel gmem AXI master interface.
- Used as the global-memory model in kernel-level simulation benches.
- FPGA loopback builds also use it as a small scratch memory.
- Independent read and write engines; one outstanding transaction per direction; IDs reflected.

Parameters:
- ADDR_WIDTH, 64, AXI address width.
- DATA_WIDTH, 32, AXI data width (power of two, 32..512).
- ID_WIDTH, 1, AXI ID width.
- USER_WIDTH, 1, AXI user width.
- MEM_ADDR_WIDTH, 10, log2 of RAM depth in DATA_WIDTH words.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- s_axi_awaddr/awlen/awsize/awburst/awid/awuser/awvalid  in  ADDR_WIDTH/8/3/2/ID/USER/1  write address channel.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata/wstrb/wlast/wuser/wvalid  in  DATA/DATA/8/1/USER/1  write data channel.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp/bid/buser/bvalid  out  2/ID/USER/1  write response channel.
- s_axi_bready  in  1  write response ready.
- s_axi_araddr/arlen/arsize/arburst/arid/aruser/arvalid  in  as AW  read address channel.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata/rresp/rlast/rid/ruser/rvalid  out  DATA/2/1/ID/USER/1  read data channel.
- s_axi_rready  in  1  read data ready.
- The awlock/awcache/awprot/awqos/awregion inputs and their ar* equivalents are accepted and ignored.

Behaviour:
- Reset values: all ready, valid and last outputs 0; bresp, rresp, bid, rid, rdata 0; both FSMs idle. RAM contents are not reset.
- Beat size is always DATA_WIDTH/8 bytes. AxSIZE is ignored. Word index = addr[MEM_ADDR_WIDTH+B-1:B], where B = log2(DATA_WIDTH/8).
- Out of range: an address with any bit set above MEM_ADDR_WIDTH+B-1 is out of range for the whole burst.
  - Writes: suppressed.
  - Reads: return zero data.
  - Response: SLVERR (2'b10).
- Burst types:
  - INCR (01): word index +1 per beat, wrapping modulo RAM depth.
  - FIXED (00): index held constant.
  - WRAP (10) and reserved (11): handled as INCR, response SLVERR.
- Write FSM:
  - W_IDLE: awready=1. On the AW handshake, latch addr, len, burst, id, user; beat count = 0; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb to the current index, increments the count and advances the index.
  - The beat count, not wlast, ends the burst. The beat with count==len is the last; go to W_RESP.
  - A wlast mismatch (wlast asserted before the final beat, or deasserted on it) sets the error flag, giving SLVERR.
  - W_RESP: bvalid=1, bid and buser = latched values. Hold until bready, then go to W_IDLE.
  - awready is 0 outside W_IDLE.
- Read FSM:
  - R_IDLE: arready=1. On the AR handshake, latch fields; go to R_FETCH.
  - R_FETCH: RAM read issued; go to R_DATA next cycle.
  - R_DATA: rvalid=1; rdata, rresp, rid, ruser and rlast are stable until rready. rlast = (count==len).
  - On the R handshake: if rlast, go to R_IDLE; else advance the index and go to R_FETCH.
  - Latency: AR handshake at cycle T gives first rvalid at T+2, then at most one beat per 2 cycles.
- Same-cycle RAM read and write to the same word: the read returns old data (read-first).
- Response codes are OKAY (00) or SLVERR (10) only; EXOKAY is never returned.
- Reset asserted mid-burst: both FSMs return to idle on the next edge, outstanding bursts are dropped, and all valid/ready outputs are 0 the cycle after.

Optional Feature:
- Macro: GMEM_SLAVE_BACKPRESSURE_EN.
- When defined: a 16-bit LFSR (seed 16'hACE1, reset to seed, taps x^16+x^14+x^13+x^11+1) advances every cycle.
  - wready in W_DATA is gated by lfsr[0].
  - rvalid entry from R_FETCH is delayed while lfsr[1]==0.
  - Data and protocol results are unchanged.
- When undefined: no LFSR; timing is exactly as in Behaviour.

Test Plan:
- Single write then read: AW addr 0x40, len 0, wdata 0xDEADBEEF, wstrb 0xF, then AR 0x40 -> bresp 00; rdata 0xDEADBEEF, rlast=1, rvalid first at T+2.
- INCR burst: write len 7 at 0x100 with data 0..7, wstrb 0x3 on beat 2, then read back -> words 0..7, except beat 2 keeps its old upper 16 bits; rlast only on beat 8.
- Wrap-around and FIXED: INCR len 3 at word index 1022 -> indices 1022, 1023, 0, 1. FIXED len 3 writes A, B, C, D to 0x20 -> readback returns 0xD.
- Errors:
  - AW addr 0x1_0000_0000 -> BRESP 10 and RAM unchanged.
  - AR at the same address -> rdata 0, rresp 10.
  - awburst 2'b10 -> SLVERR.
  - wlast early on beat 1 of len 3 -> SLVERR after 4 beats.
- Concurrency and backpressure: simultaneous AW/AR with distinct IDs 0 and 1, bready and rready held low 5 cycles -> bvalid/rvalid and the data stay stable, and bid=0, rid=1 are reflected.
- Reset mid-burst: assert reset after beat 3 of a len-7 write -> all valids 0 the next cycle; a new write then read at 0x0 completes with OKAY.
